// File: rtl/lfsr_challenge_gen.sv
// Fibonacci LFSR challenge generator: shifts a WIDTH-bit LFSR and packs its serial
// output into WIDTH-bit challenge words on a valid/ready port, with burst/continuous runs.
module lfsr_challenge_gen #(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = 64'hD800_0000_0000_0000,
    parameter logic [63:0] SEED  = 64'hCDB5_A559_AB83_F00A
) (
    input  logic             lfsrclk,
    input  logic             lfsrrstn,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [15:0]      burst_len,
    input  logic             stop,
    output logic [WIDTH-1:0] ldw,
    output logic             ldw_valid,
    input  logic             ldw_ready,
    output logic             busy,
    output logic             lockup,
    output logic             obit
);

    localparam int             KW        = $clog2(WIDTH);
    localparam logic [KW-1:0]  KLAST     = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_INIT = SEED[WIDTH-1:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s;
    logic [WIDTH-2:0] acc;
    logic [KW-1:0]    k;
    logic [15:0]      wcnt;
    logic [15:0]      blen;

    logic             fb;
    logic [WIDTH-1:0] s_shift;
    logic             at_last;
    logic             shift_en;
    logic             word_done;
    logic             burst_end;

    assign fb      = ^(s & TAP_MASK);
    assign s_shift = {s[WIDTH-2:0], fb};
    assign at_last = (k == KLAST);

    // Only the word-completing shift waits on an unaccepted word; partial words keep going.
    assign shift_en  = (state == RUN) && !(at_last && ldw_valid && !ldw_ready);
    assign word_done = shift_en && at_last;
    assign burst_end = word_done && (blen != 16'd0) && ((wcnt + 16'd1) == blen);

    assign obit = s[WIDTH-1];
    assign busy = (state == RUN);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (burst_end || stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge lfsrclk) begin
        if (!lfsrrstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge lfsrclk) begin
        if (!lfsrrstn) begin
            s         <= SEED_INIT;
            k         <= '0;
            wcnt      <= '0;
            blen      <= '0;
            ldw       <= '0;
            ldw_valid <= 1'b0;
            lockup    <= 1'b0;
        end else begin
            if (ldw_valid && ldw_ready) ldw_valid <= 1'b0;

            if (state == IDLE) begin
                if (seed_load) begin
                    if (seed == '0) begin
                        s      <= SEED_INIT;
                        lockup <= 1'b1;
                    end else begin
                        s      <= seed;
                        lockup <= 1'b0;
                    end
                end
                if (start) begin
                    blen <= burst_len;
                    k    <= '0;
                    wcnt <= '0;
                end
            end

            if (shift_en) begin
                // An all-zero state would lock the register forever; recover from SEED.
                if (s_shift == '0) begin
                    s      <= SEED_INIT;
                    lockup <= 1'b1;
                end else begin
                    s <= s_shift;
                end
                if (at_last) begin
                    k         <= '0;
                    ldw       <= {s[WIDTH-1], acc};
                    ldw_valid <= 1'b1;
                    wcnt      <= wcnt + 16'd1;
                end else begin
                    k <= k + KW'(1);
                end
            end

            if ((state == RUN) && stop) k <= '0;
        end
    end

    // NOTE: the accumulator is not reset; every bit is rewritten before a word is issued.
    always_ff @(posedge lfsrclk) begin
        if (shift_en && !at_last) acc[k] <= s[WIDTH-1];
    end

endmodule

// File: tb/tb_lfsr_challenge_gen.sv
// Directed bench for lfsr_challenge_gen: a 64-bit default instance and an 8-bit
// instance (TAPS 8'hB8), checked against hand constants and a small LFSR model.
module tb_lfsr_challenge_gen;

    localparam logic [63:0] SEED64 = 64'hCDB5_A559_AB83_F00A;
    localparam logic [7:0]  SEED8  = 8'h0A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        a_sl, a_start, a_stop, a_ready;
    logic [63:0] a_seed;
    logic [15:0] a_bl;
    logic [63:0] a_ldw;
    logic        a_valid, a_busy, a_lockup, a_obit;

    logic        b_sl, b_start, b_stop, b_ready;
    logic [7:0]  b_seed;
    logic [15:0] b_bl;
    logic [7:0]  b_ldw;
    logic        b_valid, b_busy, b_lockup, b_obit;

    lfsr_challenge_gen dut_a (
        .lfsrclk(clk), .lfsrrstn(rstn), .seed_load(a_sl), .seed(a_seed),
        .start(a_start), .burst_len(a_bl), .stop(a_stop), .ldw(a_ldw),
        .ldw_valid(a_valid), .ldw_ready(a_ready), .busy(a_busy),
        .lockup(a_lockup), .obit(a_obit)
    );

    lfsr_challenge_gen #(.WIDTH(8), .TAPS(64'hB8)) dut_b (
        .lfsrclk(clk), .lfsrrstn(rstn), .seed_load(b_sl), .seed(b_seed),
        .start(b_start), .burst_len(b_bl), .stop(b_stop), .ldw(b_ldw),
        .ldw_valid(b_valid), .ldw_ready(b_ready), .busy(b_busy),
        .lockup(b_lockup), .obit(b_obit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] step64(input logic [63:0] x);
        return {x[62:0], ^(x & 64'hD800_0000_0000_0000)};
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    logic [63:0] ma, mw, ow;
    logic [7:0]  mb, mbw, mb15;
    logic [7:0]  ew [3];
    logic [7:0]  got_w [8];
    int          first_ret, gap_err, nwords, nrec;

    initial begin
        rstn = 1'b0;
        a_sl = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0; a_seed = '0; a_bl = '0;
        b_sl = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0; b_seed = '0; b_bl = '0;
        tick();
        tick();
        check("rst_valid_a", a_valid, 0);
        check("rst_busy_a", a_busy, 0);
        check("rst_ldw_a", a_ldw, 0);
        check("rst_lockup_a", a_lockup, 0);
        check("rst_s_a", dut_a.s, SEED64);
        check("rst_s_b", dut_b.s, SEED8);
        rstn = 1'b1;

        // 64-bit single-word burst from the default seed
        ma = SEED64; mw = '0; ow = '0;
        a_bl = 16'd1; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("t1_busy_rise", a_busy, 1);
        for (int j = 0; j < 64; j++) begin
            if (j == 63) check("t1_valid_early", a_valid, 0);
            ow[j] = a_obit;
            mw[j] = ma[63];
            ma = step64(ma);
            tick();
        end
        check("t1_valid", a_valid, 1);
        check("t1_busy_end", a_busy, 0);
        check("t1_word", a_ldw, mw);
        check("t1_obit_word", ow, mw);
        check("t1_state", dut_a.s, ma);
        tick();
        check("t1_accept", a_valid, 0);

        // zero-seed lockup recovery, then a good seed clears lockup
        b_seed = 8'h00; b_sl = 1'b1;
        tick();
        b_sl = 1'b0;
        check("zs_s", dut_b.s, SEED8);
        check("zs_lockup", b_lockup, 1);
        b_seed = 8'h5A; b_sl = 1'b1;
        tick();
        b_sl = 1'b0;
        check("zs_s_5a", dut_b.s, 8'h5A);
        check("zs_lockup_clr", b_lockup, 0);

        // 8-bit continuous run from seed 01, seed load and start together
        b_seed = 8'h01; b_sl = 1'b1; b_start = 1'b1; b_bl = 16'd0; b_ready = 1'b1;
        tick();
        b_sl = 1'b0; b_start = 1'b0;
        check("t2_busy", b_busy, 1);
        check("t2_s_seed", dut_b.s, 8'h01);
        mb = 8'h01; mbw = '0; first_ret = 0; gap_err = 0; nwords = 0;
        for (int i = 1; i <= 255; i++) begin
            mbw[(i - 1) % 8] = mb[7];
            mb = step8(mb);
            tick();
            if (dut_b.s == 8'h01 && first_ret == 0) first_ret = i;
            if (b_valid) begin
                if (i % 8 != 0) gap_err++;
                nwords++;
                if (nwords == 1) check("t2_w1_hand", b_ldw, 8'h80);
                if (nwords == 2) check("t2_w2_hand", b_ldw, 8'h38);
                check($sformatf("t2_word%0d", nwords), b_ldw, mbw);
            end else if (i % 8 == 0) begin
                gap_err++;
            end
        end
        check("t2_period", first_ret, 255);
        check("t2_gaps", gap_err, 0);
        check("t2_nwords", nwords, 31);

        // stop on the completing edge: word issued, then IDLE
        mbw[7] = mb[7];
        mb = step8(mb);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        check("sc_valid", b_valid, 1);
        check("sc_word", b_ldw, mbw);
        check("sc_busy", b_busy, 0);
        check("sc_state", dut_b.s, mb);
        tick();

        // stop at k=3 of word 2, then restart from the retained state
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            mbw[i % 8] = mb[7];
            mb = step8(mb);
            tick();
            if (i == 7) check("st_word1", b_ldw, mbw);
        end
        check("st_k3", dut_b.k, 3);
        mb = step8(mb);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        check("st_busy", b_busy, 0);
        check("st_k0", dut_b.k, 0);
        check("st_state", dut_b.s, mb);
        repeat (10) tick();
        check("st_no_word2", b_valid, 0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("rs_k0", dut_b.k, 0);
        for (int i = 0; i < 8; i++) begin
            mbw[i] = mb[7];
            mb = step8(mb);
            tick();
        end
        check("rs_valid", b_valid, 1);
        check("rs_word", b_ldw, mbw);
        mb = step8(mb);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        tick();
        check("rs_idle", b_busy, 0);

        // burst of 3 with backpressure from word 1
        mb15 = '0;
        for (int i = 0; i < 24; i++) begin
            ew[i / 8][i % 8] = mb[7];
            mb = step8(mb);
            if (i == 14) mb15 = mb;
        end
        b_ready = 1'b0; b_bl = 16'd3; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (15) tick();
        check("bp_k7", dut_b.k, 7);
        repeat (4) tick();
        check("bp_k7_hold", dut_b.k, 7);
        check("bp_s_hold", dut_b.s, mb15);
        check("bp_ldw_stable", b_ldw, ew[0]);
        check("bp_valid", b_valid, 1);
        check("bp_busy", b_busy, 1);
        b_ready = 1'b1;
        nrec = 0;
        for (int t = 0; t < 20; t++) begin
            if (b_valid && b_ready && nrec < 8) begin
                got_w[nrec] = b_ldw;
                nrec++;
            end
            tick();
            if (t == 0) begin
                check("bp_nobubble_valid", b_valid, 1);
                check("bp_nobubble_word", b_ldw, ew[1]);
            end
        end
        check("bp_count", nrec, 3);
        for (int i = 0; i < 3; i++) check($sformatf("bp_word%0d", i), got_w[i], ew[i]);
        check("bp_busy_end", b_busy, 0);
        check("bp_valid_end", b_valid, 0);
        check("bp_state_end", dut_b.s, mb);

        // reset mid-run with a word pending
        a_bl = 16'd0; a_ready = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (70) tick();
        check("mr_valid_pre", a_valid, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mr_valid", a_valid, 0);
        check("mr_ldw", a_ldw, 0);
        check("mr_busy", a_busy, 0);
        check("mr_s", dut_a.s, SEED64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_challenge_gen.md
Name: lfsr_challenge_gen

Overview:
- Parametrised Fibonacci LFSR challenge generator for arbiter-PUF characterisation.
- Shifts a WIDTH-bit LFSR and serialises its output bit into WIDTH-bit challenge words.
- Presents each word on a valid/ready interface, with burst or continuous mode, runtime seed load, backpressure stall and all-zero lockup recovery.
- Sits between the host/UART control logic and the PUF challenge register.

Parameters:
- WIDTH, 64: LFSR length and challenge word width (4 to 64).
- TAPS, 64'hD800_0000_0000_0000: feedback mask; bit i set means stage i is XORed into feedback. The default gives stages 63, 62, 60, 59, i.e. x^64+x^4+x^3+x+1.
- SEED, 64'hCDB5_A559_AB83_F00A: reset state and substitute for an all-zero seed. Only bits [WIDTH-1:0] are used.

Ports:
- lfsrclk  in  1  single clock; all logic on the rising edge.
- lfsrrstn  in  1  synchronous, active-low reset.
- seed_load  in  1  load seed into the LFSR; honoured in IDLE only.
- seed  in  WIDTH  seed value.
- start  in  1  begin generation; honoured in IDLE only.
- burst_len  in  16  words to produce; 0 means continuous until stop.
- stop  in  1  abort generation; honoured in RUN only.
- ldw  out  WIDTH  challenge word.
- ldw_valid  out  1  ldw holds an unaccepted word.
- ldw_ready  in  1  consumer accepts ldw when ldw_valid and ldw_ready are both high.
- busy  out  1  high in RUN.
- lockup  out  1  sticky; set when an all-zero state was substituted.
- obit  out  1  combinational s[WIDTH-1], the current serial output.

Behaviour:
- Reset (lfsrrstn=0 at an edge): s=SEED, k=0, wcnt=0, ldw=0, ldw_valid=0, busy=0, lockup=0, state IDLE. Reset overrides every other input, including mid-RUN with a word pending; the pending word is lost.
- Shift step: fb = XOR-reduce(s & TAPS), then s <= {s[WIDTH-2:0], fb}. On the same edge, acc[k] <= s[WIDTH-1], so bit j of a word is the obit value sampled at the word's j-th shift.
- k counts 0..WIDTH-1 and wraps to 0 on the shift that completes a word.
- Word completion (shift with k==WIDTH-1): ldw <= {s[WIDTH-1], acc[WIDTH-2:0]}, ldw_valid <= 1, wcnt <= wcnt+1.
- Stall: shift_en = RUN and not (k==WIDTH-1 and ldw_valid and not ldw_ready).
  - Partial words keep accumulating; only the completing shift waits.
  - If the old word is accepted on the same edge as a new word completes, the new word loads with no bubble.
- Throughput with ldw_ready held high: one word every WIDTH cycles.
- ldw_valid clears on acceptance unless a new word completes on that same edge.
- IDLE:
  - seed_load: s <= seed. If seed==0, s <= SEED and lockup <= 1. If seed!=0, lockup <= 0.
  - start: latch burst_len, k <= 0, wcnt <= 0, go to RUN; busy=1 from the next cycle.
  - start and seed_load in the same cycle: the seed is loaded and RUN is entered; the first shift uses the new seed on the next edge.
  - stop is ignored in IDLE.
- RUN:
  - seed_load and start are ignored.
  - stop: discard the partial word, k <= 0, go to IDLE; the LFSR state is retained. A pending ldw stays valid until accepted.
  - stop and word completion on the same edge: the completed word is issued, then IDLE.
  - Burst end: on the completion edge where wcnt+1 == burst_len (burst_len != 0), go to IDLE with busy=0. The last word remains valid.
  - With burst_len=0, wcnt wraps at 16 bits and is ignored.
- Lockup: if the next state would be all-zero (non-primitive TAPS), load SEED instead and set lockup.
- Latency: with start sampled at edge 0 and ldw_ready=1, shifts occur at edges 1..WIDTH. ldw_valid is first seen high after edge WIDTH, i.e. WIDTH cycles after start.
- ldw is stable whenever ldw_valid=1 and the word has not been accepted.

Test Plan:
- Defaults, reset, no seed load, start with burst_len=1, ready=1:
  - busy rises after the start edge.
  - ldw_valid rises 64 cycles after start; bit j of ldw equals obit sampled before shift j.
  - busy=0 on the same edge; the word matches a reference model seeded with 64'hCDB5_A559_AB83_F00A.
- WIDTH=8, TAPS=8'hB8, seed 8'h01, continuous, ready=1:
  - the LFSR state returns to 8'h01 after exactly 255 shifts and not before;
  - one word every 8 cycles with no gaps.
- WIDTH=8, burst_len=3, ready low from word 1:
  - the LFSR halts with k==7 and ldw is stable;
  - raising ready resumes shifting and produces exactly 3 words;
  - the words equal those from a zero-backpressure run.
- Zero seed: seed_load with seed=0 in IDLE → s=SEED, lockup=1. A later seed_load with 8'h5A → lockup=0.
- stop at k=3 of word 2 in continuous mode → no word 2 emitted, busy=0 next cycle. A restart continues from the retained state with k=0.
- Reset mid-RUN with ldw_valid=1 → next cycle: ldw_valid=0, ldw=0, busy=0, s=SEED.
